// File: rtl/vid_frame_sched.sv
// Frame timing scheduler: pulls pixels with ready/valid, emits a registered
// pixel stream with DE, line-end hsync and frame-end vsync pulses.
module vid_frame_sched #(
    parameter int SIZE_X = 64,
    parameter int SIZE_Y = 64,
    parameter int H_SIZE = 83,
    parameter int V_SIZE = 70,
    parameter int LEN_X  = $clog2(H_SIZE),
    parameter int LEN_Y  = $clog2(V_SIZE)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic [23:0] i_pixel_in,
    input  logic        i_pixel_valid,
    output logic        o_pixel_ready,
    output logic [23:0] o_pixel_out,
    output logic        o_de_out,
    output logic        o_hsync_out,
    output logic        o_vsync_out,
    output logic        o_frame_done,
    output logic        o_underflow
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_HBLANK,
        ST_VBLANK
    } state_t;

    localparam logic [LEN_X-1:0] X_ACT  = LEN_X'(SIZE_X);
    localparam logic [LEN_X-1:0] X_LAST = LEN_X'(SIZE_X - 1);
    localparam logic [LEN_X-1:0] H_LAST = LEN_X'(H_SIZE - 1);
    localparam logic [LEN_Y-1:0] Y_LAST = LEN_Y'(SIZE_Y - 1);
    localparam logic [LEN_Y-1:0] V_LAST = LEN_Y'(V_SIZE - 1);

    state_t           r_state;
    logic [LEN_X-1:0] r_hcnt;
    logic [LEN_Y-1:0] r_vcnt;
    logic [23:0]      r_pixel;
    logic             r_de;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_frame_done;
    logic             r_underflow;
    logic             w_ready;

    assign w_ready = (r_state == ST_ACTIVE) && (r_hcnt < X_ACT);

    assign o_pixel_ready = w_ready;
    assign o_pixel_out   = r_pixel;
    assign o_de_out      = r_de;
    assign o_hsync_out   = r_hsync;
    assign o_vsync_out   = r_vsync;
    assign o_frame_done  = r_frame_done;
    assign o_underflow   = r_underflow;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_hcnt       <= '0;
            r_vcnt       <= '0;
            r_pixel      <= '0;
            r_de         <= 1'b0;
            r_hsync      <= 1'b0;
            r_vsync      <= 1'b0;
            r_frame_done <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_de         <= w_ready;
            r_hsync      <= 1'b0;
            r_vsync      <= 1'b0;
            r_frame_done <= 1'b0;
            // A missing pixel still occupies its slot; timing never stalls.
            if (w_ready) begin
                r_pixel <= i_pixel_valid ? i_pixel_in : 24'h0;
                if (!i_pixel_valid) begin
                    r_underflow <= 1'b1;
                end
            end
            unique case (r_state)
                ST_IDLE: begin
                    r_pixel <= '0;
                    if (i_enable) begin
                        r_state     <= ST_ACTIVE;
                        r_hcnt      <= '0;
                        r_vcnt      <= '0;
                        r_underflow <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    r_hcnt <= r_hcnt + 1'b1;
                    if (r_hcnt == X_LAST) begin
                        r_state <= ST_HBLANK;
                    end
                end
                ST_HBLANK: begin
                    if (r_hcnt == X_ACT) begin
                        r_hsync <= 1'b1;
                    end
                    if (r_hcnt == H_LAST) begin
                        r_hcnt <= '0;
                        r_vcnt <= r_vcnt + 1'b1;
                        if (r_vcnt == Y_LAST) begin
                            r_state      <= ST_VBLANK;
                            r_vsync      <= 1'b1;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_state <= ST_ACTIVE;
                        end
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                ST_VBLANK: begin
                    if (r_hcnt == H_LAST) begin
                        r_hcnt <= '0;
                        // enable only matters here, at the frame boundary
                        if (r_vcnt == V_LAST) begin
                            r_vcnt  <= '0;
                            r_state <= i_enable ? ST_ACTIVE : ST_IDLE;
                        end else begin
                            r_vcnt <= r_vcnt + 1'b1;
                        end
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/vid_frame_sched.md
Name: vid_frame_sched

Overview:
- Controller that schedules a raw pixel stream into video frame timing: active line, horizontal blanking, vertical blanking.
- Pulls pixels from an upstream source (file reader, FIFO or vision core) with a ready/valid handshake.
- Drives registered pixel_out/de_out/hsync_out/vsync_out to the downstream vision pipeline and the HDMI output path.
- Timing is free-running once a frame starts; a late upstream source never stalls the timing and is flagged as underflow.

Parameters:
- SIZE_X, 64, active pixels per line.
- SIZE_Y, 64, active lines per frame.
- H_SIZE, 83, total clocks per line (active + blank); must be > SIZE_X+1.
- V_SIZE, 70, total lines per frame (active + blank); must be > SIZE_Y.
- LEN_X, $clog2(H_SIZE), horizontal counter width.
- LEN_Y, $clog2(V_SIZE), vertical counter width.

Ports:
- clk  in  1  pixel clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run request; sampled only at frame boundaries.
- pixel_in  in  24  upstream pixel, {B,G,R}, with R in [7:0].
- pixel_valid  in  1  pixel_in is valid.
- pixel_ready  out  1  combinational; high while HCnt < SIZE_X in state ACTIVE.
- pixel_out  out  24  registered pixel to downstream.
- de_out  out  1  registered data enable.
- hsync_out  out  1  one-clock line-end pulse.
- vsync_out  out  1  one-clock frame-end pulse.
- frame_done  out  1  one-clock pulse, coincident with vsync_out.
- underflow  out  1  sticky error flag; cleared only by rst or by leaving IDLE.

Behaviour:
- Reset (async, immediate):
  - All outputs 0.
  - HCnt = 0, VCnt = 0, state = IDLE.
  - Reset mid-line or mid-frame aborts with no further pulses.
- State machine:
  - States: IDLE, ACTIVE, HBLANK, VBLANK.
  - IDLE: outputs low. When enable = 1, next state is ACTIVE with HCnt = 0, VCnt = 0, and underflow cleared.
  - ACTIVE: pixel_ready = 1 while HCnt < SIZE_X; HCnt increments each clock. When HCnt == SIZE_X-1, next state is HBLANK.
  - HBLANK: HCnt runs SIZE_X .. H_SIZE-1.
    - At HCnt == SIZE_X, hsync_out is asserted on the following edge for exactly 1 clock.
    - At HCnt == H_SIZE-1: HCnt <= 0.
    - If VCnt == SIZE_Y-1: go to VBLANK, assert vsync_out and frame_done for 1 clock on that edge, and set VCnt <= VCnt+1.
    - Otherwise: go to ACTIVE with VCnt <= VCnt+1.
  - VBLANK: whole H_SIZE-clock lines with no de_out, no hsync_out and pixel_ready = 0.
    - At the end of the line with VCnt == V_SIZE-1: VCnt <= 0.
    - Then go to ACTIVE if enable = 1, else IDLE.
- Handshake:
  - A transfer occurs when pixel_ready && pixel_valid.
  - Latency: pixel_out and de_out update on the next edge.
  - de_out = 1 for every ACTIVE clock, regardless of pixel_valid.
  - If pixel_valid = 0 during a ready clock: pixel_out <= 24'h0, de_out <= 1, underflow <= 1. Timing does not stall.
  - pixel_valid while not ready is ignored; pixel_out holds its last value and de_out = 0.
- enable deassert mid-frame: the current frame, including vertical blanking, completes, then the block enters IDLE. Reassert during IDLE starts the next frame on the following clock.
- Counts per frame: exactly SIZE_X*SIZE_Y de_out clocks, SIZE_Y hsync_out pulses and one vsync_out pulse. Frame period is H_SIZE*V_SIZE clocks, plus 1 IDLE→ACTIVE clock when starting from IDLE.
- Counters never exceed H_SIZE-1 / V_SIZE-1. Wrap-around happens only as described above.

Test Plan:
- Reset: hold rst with enable = 1 → all outputs 0 and pixel_ready = 0. Release rst → pixel_ready = 1 on the 2nd clock after release.
- Single frame with SIZE_X=4, SIZE_Y=2, H_SIZE=7, V_SIZE=3, pixel_valid = 1, incrementing pixel_in = 1..8, enable dropped after start:
  - de_out high for exactly 8 clocks, with pixel_out 1..8 in order.
  - 2 hsync_out pulses, each 1 clock after the 4th de_out of its line.
  - 1 vsync_out/frame_done pulse.
  - Block returns to IDLE after 21 clocks.
- Underflow: pixel_valid = 0 for the 3rd pixel of line 0 → pixel_out = 0 with de_out = 1 at that slot, underflow = 1 and held until the next IDLE→ACTIVE. Timing is identical to the no-underflow frame.
- Continuous: enable held high for 3 frames at default parameters → vsync_out period 5810 clocks, 4096 de_out clocks per frame, no IDLE gap between frames.
- Reset mid-line (rst asserted at HCnt = 2 in line 1) → outputs 0 immediately, no vsync_out. After release, a fresh frame starts from VCnt = 0.
- pixel_valid high during HBLANK/VBLANK → no transfer, pixel_out unchanged, de_out = 0.
